// File: rtl/uart_rx_ctrl_if.sv
// Receive-side bus between the rx edge detector, uart_rx_ctrl and the byte consumer.
// The master drives the line and strobe. The slave (uart_rx_ctrl) returns the word and status pulses.
interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx;
  logic                 rx_fall;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    output rx, rx_fall,
    input  data_out, data_valid, frame_err, parity_err, busy
  );

  modport slave (
    input  rx, rx_fall,
    output data_out, data_valid, frame_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame-level UART receive sequencer.
// It qualifies the start bit, samples each data bit at mid-bit and shifts the bits in LSB-first.
// It then checks the stop bit and issues one data_valid or one frame_err pulse per frame.
// Optional feature macro: UART_RX_PARITY_EN. It adds a parity bit before the stop bit and drives parity_err.
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  // Stop elaboration on a parameter set the sequencer cannot support.
  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_ctrl: parameter out of range");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               r_state, w_state;
  logic [CNT_W-1:0]     r_cnt, w_cnt;
  logic [IDX_W-1:0]     r_idx, w_idx;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic [DATA_BITS-1:0] r_data, w_data;
  logic                 r_data_valid, w_data_valid;
  logic                 r_frame_err, w_frame_err;
  logic                 r_parity_err, w_parity_err;
  logic                 r_busy, w_busy;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_mis, w_par_mis;
`endif

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_mis    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_idx        <= w_idx;
      r_shift      <= w_shift;
      r_data       <= w_data;
      r_data_valid <= w_data_valid;
      r_frame_err  <= w_frame_err;
      r_parity_err <= w_parity_err;
      r_busy       <= w_busy;
`ifdef UART_RX_PARITY_EN
      r_par_mis    <= w_par_mis;
`endif
    end
  end

  // Next-state logic: the bit timer free-runs and is cleared at each sample point.
  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt + CNT_W'(1);
    w_idx        = r_idx;
    w_shift      = r_shift;
    w_data       = r_data;
    w_data_valid = 1'b0;
    w_frame_err  = 1'b0;
    w_parity_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_mis    = r_par_mis;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (bus.rx_fall) begin
          w_state = S_START;
        end
      end
      S_START: begin
        // A start bit that is high again at half a bit is a glitch.
        if (r_cnt == CNT_HALF) begin
          w_cnt   = '0;
          w_idx   = '0;
          w_state = bus.rx ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_BIT) begin
          w_cnt   = '0;
          w_shift = {bus.rx, r_shift[DATA_BITS-1:1]};
          if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state = S_PARITY;
`else
            w_state = S_STOP;
`endif
          end else begin
            w_idx = r_idx + IDX_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == CNT_BIT) begin
          w_cnt     = '0;
          w_par_mis = ((^r_shift) ^ bus.rx) != 1'(PARITY_ODD);
          w_state   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // The frame is resolved at mid-stop, so the next start edge can follow half a bit later.
        if (r_cnt == CNT_BIT) begin
          w_cnt   = '0;
          w_state = S_IDLE;
          if (bus.rx) begin
            w_data       = r_shift;
            w_data_valid = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_parity_err = r_par_mis;
`endif
          end else begin
            w_frame_err = 1'b1;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    w_busy = (w_state != S_IDLE);
  end

  // Outputs come straight from registers.
  assign bus.data_out   = r_data;
  assign bus.data_valid = r_data_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.parity_err = r_parity_err;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl.
// Stimulus is a per-cycle rx waveform, and rx_fall is derived from that waveform.
// A line-level reference model predicts the busy trace and the output pulses.
module tb_uart_rx_ctrl;

  localparam int C = 16;
  localparam int N = 8;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
  localparam bit PE_ON = 1'b1;
`else
  localparam int P = 0;
  localparam bit PE_ON = 1'b0;
`endif
  localparam int PODD = 0;
  localparam int LAT  = C / 2 + (N + 1 + P) * C + 1;

  typedef struct {
    int           cyc;
    bit           ferr;
    logic [N-1:0] data;
    bit           pe;
  } ev_t;

  typedef struct {
    logic [N-1:0] data;
    bit           par_bit;
    bit           stop;
    int           gap;
    bit           exp_ferr;
    logic [N-1:0] exp_out;
    bit           exp_pe;
  } row_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int           n_tests = 0;
  int           n_fail  = 0;
  bit           wave[$];
  bit           line_prev = 1'b1;
  ev_t          obs_q[$];
  ev_t          exp_q[$];
  bit           busy_q[$];
  bit           bexp_q[$];
  int           n_overlap;
  logic [N-1:0] m_data;

  uart_rx_ctrl_if #(.DATA_BITS(N)) bus ();

  uart_rx_ctrl #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (N),
    .PARITY_ODD  (PODD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit line_at(input int i);
    return (i < wave.size()) ? wave[i] : 1'b1;
  endfunction

  task automatic push_frame(input logic [N-1:0] d, input bit pbit, input bit stop,
                            input int stop_len, input int gap);
    repeat (C) wave.push_back(1'b0);
    for (int k = 0; k < N; k++) repeat (C) wave.push_back(d[k]);
    if (P != 0) repeat (C) wave.push_back(pbit);
    repeat (stop_len) wave.push_back(stop);
    repeat (gap) wave.push_back(1'b1);
  endtask

  task automatic mark_busy(input int a, input int b);
    for (int j = a; j <= b; j++) if (j < bexp_q.size()) bexp_q[j] = 1'b1;
  endtask

  // Reference model: it walks the line as a receiver would and predicts the pulses and busy intervals.
  task automatic model_wave(input bit lp);
    int           t, s, e, len;
    logic [N-1:0] d;
    bit           pe, prev;
    ev_t          ev;
    len = wave.size();
    exp_q.delete();
    bexp_q.delete();
    for (int i = 0; i < len; i++) bexp_q.push_back(1'b0);
    t = 0;
    while (t < len) begin
      prev = (t == 0) ? lp : wave[t-1];
      if (prev && !wave[t]) begin
        s = t + C / 2;
        if (line_at(s)) begin
          mark_busy(t + 1, s);
          t = s + 1;
        end else begin
          for (int k = 0; k < N; k++) d[k] = line_at(s + (k + 1) * C);
          pe = 1'b0;
          if (P != 0) pe = (((^d) ^ line_at(s + (N + 1) * C)) != 1'(PODD));
          e = s + (N + 1 + P) * C;
          mark_busy(t + 1, e);
          if (line_at(e)) begin
            m_data = d;
            ev = '{e + 1, 1'b0, d, pe};
          end else begin
            ev = '{e + 1, 1'b1, m_data, 1'b0};
          end
          exp_q.push_back(ev);
          t = e + 1;
        end
      end else begin
        t++;
      end
    end
  endtask

  // Drive the waveform one cycle at a time and capture the outputs 1 time unit after each edge.
  task automatic run_wave();
    bit  prev;
    ev_t ev;
    obs_q.delete();
    busy_q.delete();
    n_overlap = 0;
    prev = line_prev;
    for (int i = 0; i < wave.size(); i++) begin
      @(posedge clk);
      #1;
      if (bus.data_valid && bus.frame_err) n_overlap++;
      if (bus.data_valid) begin
        ev = '{i, 1'b0, bus.data_out, bus.parity_err};
        obs_q.push_back(ev);
      end
      if (bus.frame_err) begin
        ev = '{i, 1'b1, bus.data_out, bus.parity_err};
        obs_q.push_back(ev);
      end
      busy_q.push_back(bus.busy);
      bus.rx      = wave[i];
      bus.rx_fall = prev & ~wave[i];
      prev        = wave[i];
    end
    line_prev = prev;
  endtask

  task automatic compare_model(input string name);
    int mism, first;
    check({name, " pulse count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s ev%0d cycle", name, i), obs_q[i].cyc, exp_q[i].cyc);
      check($sformatf("%s ev%0d kind", name, i), int'(obs_q[i].ferr), int'(exp_q[i].ferr));
      check($sformatf("%s ev%0d data_out", name, i), int'(obs_q[i].data), int'(exp_q[i].data));
      check($sformatf("%s ev%0d parity_err", name, i), int'(obs_q[i].pe), int'(exp_q[i].pe));
    end
    mism  = 0;
    first = -1;
    for (int i = 0; i < busy_q.size(); i++) begin
      if (busy_q[i] != bexp_q[i]) begin
        mism++;
        if (first < 0) first = i;
      end
    end
    if (mism != 0) $display("  busy differs first at cycle %0d", first);
    check({name, " busy mismatches"}, mism, 0);
    check({name, " pulse overlap"}, n_overlap, 0);
  endtask

  row_t rows[9];
  int   starts[9];

  initial begin
    bus.rx      = 1'b1;
    bus.rx_fall = 1'b0;
    m_data      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset data_out", int'(bus.data_out), 0);
    check("reset data_valid", int'(bus.data_valid), 0);
    check("reset frame_err", int'(bus.frame_err), 0);
    check("reset parity_err", int'(bus.parity_err), 0);
    check("reset busy", int'(bus.busy), 0);
    rst_n = 1'b1;

    // Directed frames with hand-computed results. Rows 3 and 4 are back to back.
    rows[0] = '{8'hA5, 1'b0, 1'b1, 20, 1'b0, 8'hA5, 1'b0};
    rows[1] = '{8'h11, 1'b0, 1'b1, 20, 1'b0, 8'h11, 1'b0};
    rows[2] = '{8'h7E, 1'b0, 1'b0, 20, 1'b1, 8'h11, 1'b0};
    rows[3] = '{8'h00, 1'b0, 1'b1, 0,  1'b0, 8'h00, 1'b0};
    rows[4] = '{8'hFF, 1'b0, 1'b1, 20, 1'b0, 8'hFF, 1'b0};
    rows[5] = '{8'h55, 1'b1, 1'b1, 20, 1'b0, 8'h55, PE_ON};
    rows[6] = '{8'h55, 1'b0, 1'b1, 20, 1'b0, 8'h55, 1'b0};
    rows[7] = '{8'h3C, 1'b0, 1'b0, 5,  1'b1, 8'h55, 1'b0};
    rows[8] = '{8'hC6, 1'b0, 1'b1, 40, 1'b0, 8'hC6, 1'b0};
    wave.delete();
    for (int r = 0; r < 9; r++) begin
      starts[r] = wave.size();
      push_frame(rows[r].data, rows[r].par_bit, rows[r].stop, C, rows[r].gap);
    end
    model_wave(line_prev);
    run_wave();
    compare_model("table");
    for (int r = 0; r < 9; r++) begin
      if (r < obs_q.size()) begin
        check($sformatf("row%0d latency", r), obs_q[r].cyc - starts[r], LAT);
        check($sformatf("row%0d frame_err", r), int'(obs_q[r].ferr), int'(rows[r].exp_ferr));
        check($sformatf("row%0d data_out", r), int'(obs_q[r].data), int'(rows[r].exp_out));
        check($sformatf("row%0d parity_err", r), int'(obs_q[r].pe), int'(rows[r].exp_pe));
      end else begin
        check($sformatf("row%0d pulse present", r), 0, 1);
      end
    end

    // False start: the line is low for 4 cycles and is rejected at the half-bit sample.
    wave.delete();
    repeat (4) wave.push_back(1'b0);
    repeat (40) wave.push_back(1'b1);
    model_wave(line_prev);
    run_wave();
    compare_model("glitch");
    check("glitch busy@8", int'(busy_q[8]), 1);
    check("glitch busy@9", int'(busy_q[9]), 0);
    check("glitch pulses", obs_q.size(), 0);

    // Reset asserted during data bit 4; the partial frame must vanish.
    wave.delete();
    push_frame(8'hC3, 1'b0, 1'b1, C, 0);
    while (wave.size() > 5 * C + 3) void'(wave.pop_back());
    run_wave();
    check("pre-reset pulses", obs_q.size(), 0);
    rst_n       = 1'b0;
    bus.rx      = 1'b1;
    bus.rx_fall = 1'b0;
    line_prev   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("midreset%0d busy", i), int'(bus.busy), 0);
      check($sformatf("midreset%0d data_out", i), int'(bus.data_out), 0);
      check($sformatf("midreset%0d pulses", i),
            int'(bus.data_valid | bus.frame_err | bus.parity_err), 0);
    end
    rst_n  = 1'b1;
    m_data = '0;
    wave.delete();
    repeat (3) wave.push_back(1'b1);
    push_frame(8'h3C, 1'b0, 1'b1, C, 40);
    model_wave(line_prev);
    run_wave();
    compare_model("post-reset");
    if (obs_q.size() > 0) check("post-reset data_out", int'(obs_q[0].data), 8'h3C);
    else check("post-reset pulse present", 0, 1);

    // Random traffic: frames with random data, parity, stop value, shortened stop bits, gaps and glitches.
    for (int it = 0; it < 8; it++) begin
      int           nfr, sel, slen, gap;
      bit           stop;
      logic [N-1:0] d;
      wave.delete();
      repeat (2) wave.push_back(1'b1);
      nfr = $urandom_range(5, 2);
      for (int f = 0; f < nfr; f++) begin
        sel = $urandom_range(9, 0);
        if (sel == 0) begin
          repeat ($urandom_range(C / 2 - 1, 1)) wave.push_back(1'b0);
          repeat ($urandom_range(2 * C, C)) wave.push_back(1'b1);
        end else begin
          d    = N'($urandom);
          stop = ($urandom_range(3, 0) != 0);
          slen = stop ? $urandom_range(C, C / 2 + 1) : C;
          gap  = stop ? $urandom_range(12, 0) : $urandom_range(12, 1);
          push_frame(d, 1'($urandom), stop, slen, gap);
        end
      end
      repeat (60) wave.push_back(1'b1);
      model_wave(line_prev);
      run_wave();
      compare_model($sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
